// File: rtl/boid_frame_scheduler.sv
// Frame scheduler for the double-buffered 1-bit boid occupancy store: clear sweep,
// bank swapping on frame_tick and round-robin arbitration of engine writes.
module boid_frame_scheduler #(
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_tick,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          wr_en,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    output logic                          wr_data,
    output logic                          bank_sel,
    output logic                          clr_en,
    output logic                          clr_all,
    output logic [ADDR_WIDTH-1:0]         clr_addr,
    output logic                          swap_pulse,
    output logic                          overrun,
    output logic [7:0]                    drop_cnt
);
    localparam int RR_W = $clog2(NUM_REQ);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [RR_W:0] NREQ = (RR_W + 1)'(NUM_REQ);

    typedef enum logic [1:0] {INIT, CLEAR, READY, SWAP} state_t;

    state_t                 state_q, state_d;
    logic                   bank_q, bank_d;
    logic [ADDR_WIDTH-1:0]  clr_addr_q, clr_addr_d;
    logic                   clr_en_q, clr_en_d;
    logic                   clr_all_q, clr_all_d;
    logic                   swap_q, swap_d;
    logic                   pending_q, pending_d;
    logic                   overrun_q, overrun_d;
    logic [7:0]             drop_q, drop_d;
    logic [RR_W-1:0]        rr_q, rr_d;
    logic                   wr_en_q;
    logic [ADDR_WIDTH-1:0]  wr_addr_q;
    logic                   wr_data_q;

    logic [NUM_REQ-1:0]     vv_rot;
    logic                   found;
    logic [RR_W:0]          gidx;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic                   sel_data;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Rotate valids so position 0 is rr_q; the lowest set bit wins.
    always_comb begin
        vv_rot = NUM_REQ'({req_valid, req_valid} >> rr_q);
        found  = 1'b0;
        gidx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (vv_rot[k]) begin
                found = 1'b1;
                gidx  = {1'b0, rr_q} + (RR_W + 1)'(k);
            end
        end
        if (gidx >= NREQ) gidx = gidx - NREQ;
        found     = found && ((state_q == CLEAR) || (state_q == READY));
        req_ready = '0;
        sel_addr  = '0;
        sel_data  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (found && (gidx == (RR_W + 1)'(i))) begin
                req_ready[i] = 1'b1;
                sel_addr     = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data     = req_data[i];
            end
        end
        rr_d = rr_q;
        if (found) rr_d = (gidx == NREQ - 1'b1) ? '0 : gidx[RR_W-1:0] + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        bank_d     = bank_q;
        clr_addr_d = clr_addr_q;
        clr_en_d   = 1'b0;
        clr_all_d  = 1'b0;
        pending_d  = pending_q;
        overrun_d  = overrun_q;
        drop_d     = drop_q;
        case (state_q)
            INIT: begin
                clr_en_d  = 1'b1;
                clr_all_d = 1'b1;
                // First cycle after reset only raises the strobe at address 0.
                if (clr_en_q) begin
                    if (clr_addr_q == LAST_ADDR) begin
                        state_d    = READY;
                        clr_en_d   = 1'b0;
                        clr_all_d  = 1'b0;
                        clr_addr_d = '0;
                    end else begin
                        clr_addr_d = clr_addr_q + 1'b1;
                    end
                end
                if (frame_tick) drop_d = sat_inc(drop_q);
            end
            CLEAR: begin
                clr_en_d = 1'b1;
                if (frame_tick) begin
                    if (pending_q) begin
                        drop_d = sat_inc(drop_q);
                    end else begin
                        pending_d = 1'b1;
                        overrun_d = 1'b1;
                    end
                end
                if (clr_addr_q == LAST_ADDR) begin
                    clr_en_d   = 1'b0;
                    clr_addr_d = '0;
                    state_d    = (pending_q || frame_tick) ? SWAP : READY;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            READY: begin
                if (frame_tick) state_d = SWAP;
            end
            SWAP: begin
                bank_d     = ~bank_q;
                pending_d  = 1'b0;
                clr_addr_d = '0;
                clr_en_d   = 1'b1;
                state_d    = CLEAR;
                if (frame_tick) drop_d = sat_inc(drop_q);
            end
            default: state_d = INIT;
        endcase
        swap_d = (state_d == SWAP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= INIT;
            bank_q     <= 1'b0;
            clr_addr_q <= '0;
            clr_en_q   <= 1'b0;
            clr_all_q  <= 1'b0;
            swap_q     <= 1'b0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            drop_q     <= '0;
            rr_q       <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bank_q     <= bank_d;
            clr_addr_q <= clr_addr_d;
            clr_en_q   <= clr_en_d;
            clr_all_q  <= clr_all_d;
            swap_q     <= swap_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            drop_q     <= drop_d;
            rr_q       <= rr_d;
            wr_en_q    <= found;
            wr_addr_q  <= sel_addr;
            wr_data_q  <= sel_data;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign bank_sel   = bank_q;
    assign clr_en     = clr_en_q;
    assign clr_all    = clr_all_q;
    assign clr_addr   = clr_addr_q;
    assign swap_pulse = swap_q;
    assign overrun    = overrun_q;
    assign drop_cnt   = drop_q;
endmodule

// File: tb/tb_boid_frame_scheduler.sv
// Randomized bench for boid_frame_scheduler against an event-level reference model.
module tb_boid_frame_scheduler;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int N     = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            frame_tick = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0]    req_data = '0;
    logic [N-1:0]    req_ready;
    logic            wr_en, wr_data, bank_sel, clr_en, clr_all, swap_pulse, overrun;
    logic [AW-1:0]   wr_addr, clr_addr;
    logic [7:0]      drop_cnt;

    boid_frame_scheduler #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .NUM_REQ(N)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .bank_sel(bank_sel), .clr_en(clr_en), .clr_all(clr_all), .clr_addr(clr_addr),
        .swap_pulse(swap_pulse), .overrun(overrun), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int passes = 0;
    int checks = 0;

    // Reference model: sweep position (-1 = not sweeping), pending swap, bank, counters.
    bit            m_init_wait;
    int            m_sweep;
    bit            m_all, m_swap, m_bank, m_pending, m_overrun;
    int            m_drop, m_rr, m_swaps;
    bit            m_wr_v, m_wr_d;
    logic [AW-1:0] m_wr_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_init_wait = 1'b1; m_sweep = -1; m_all = 1'b0; m_swap = 1'b0;
        m_bank = 1'b0; m_pending = 1'b0; m_overrun = 1'b0; m_drop = 0;
        m_rr = 0; m_swaps = 0; m_wr_v = 1'b0; m_wr_a = '0; m_wr_d = 1'b0;
    endtask

    task automatic bump();
        if (m_drop < 255) m_drop++;
    endtask

    function automatic int pick(input logic [N-1:0] v);
        if (m_init_wait || m_swap || (m_sweep >= 0 && m_all)) return -1;
        for (int k = 0; k < N; k++) begin
            if (v[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_edge(input bit ft, input int g, input logic [AW-1:0] ga, input bit gd);
        m_wr_v = (g >= 0); m_wr_a = ga; m_wr_d = gd;
        if (g >= 0) m_rr = (g + 1) % N;
        if (m_init_wait) begin
            m_init_wait = 1'b0; m_sweep = 0; m_all = 1'b1;
            if (ft) bump();
        end else if (m_swap) begin
            m_swap = 1'b0; m_bank = !m_bank; m_pending = 1'b0;
            m_sweep = 0; m_all = 1'b0; m_swaps++;
            if (ft) bump();
        end else if (m_sweep >= 0 && m_all) begin
            if (ft) bump();
            if (m_sweep == DEPTH - 1) begin m_sweep = -1; m_all = 1'b0; end
            else m_sweep++;
        end else if (m_sweep >= 0) begin
            if (ft) begin
                if (m_pending) bump();
                else begin m_pending = 1'b1; m_overrun = 1'b1; end
            end
            if (m_sweep == DEPTH - 1) begin m_sweep = -1; m_swap = m_pending; end
            else m_sweep++;
        end else if (ft) begin
            m_swap = 1'b1;
        end
    endtask

    task automatic check_outputs();
        chk("bank_sel", 32'(bank_sel), 32'(m_bank));
        chk("clr_en", 32'(clr_en), 32'(m_sweep >= 0));
        if (m_sweep >= 0) begin
            chk("clr_all", 32'(clr_all), 32'(m_all));
            chk("clr_addr", 32'(clr_addr), 32'(m_sweep));
        end else begin
            chk("clr_all_idle", 32'(clr_all), 32'(0));
        end
        chk("swap_pulse", 32'(swap_pulse), 32'(m_swap));
        chk("overrun", 32'(overrun), 32'(m_overrun));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("wr_en", 32'(wr_en), 32'(m_wr_v));
        if (m_wr_v) begin
            chk("wr_addr", 32'(wr_addr), 32'(m_wr_a));
            chk("wr_data", 32'(wr_data), 32'(m_wr_d));
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        chk("rst_bank_sel", 32'(bank_sel), 32'(0));
        chk("rst_clr_en", 32'(clr_en), 32'(0));
        chk("rst_clr_addr", 32'(clr_addr), 32'(0));
        chk("rst_wr_en", 32'(wr_en), 32'(0));
        chk("rst_swap_pulse", 32'(swap_pulse), 32'(0));
        chk("rst_overrun", 32'(overrun), 32'(0));
        chk("rst_drop_cnt", 32'(drop_cnt), 32'(0));
    endtask

    // One clock: drive inputs, check the combinational grant, then the registered outputs.
    task automatic cyc(input bit ft, input logic [N-1:0] v);
        int            g;
        logic [N-1:0]  exp_rdy;
        logic [AW-1:0] ga;
        bit            gd;
        frame_tick = ft;
        req_valid  = v;
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'($urandom);
        req_data = N'($urandom);
        #1;
        g = pick(v);
        exp_rdy = '0;
        ga = '0;
        gd = 1'b0;
        if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            ga = req_addr[g*AW +: AW];
            gd = req_data[g];
        end
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        @(posedge clk);
        model_edge(ft, g, ga, gd);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        req_valid = '1;
        reset = 1'b0;
        #1;
        model_reset();
        check_reset_vals();
        req_valid = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int n_all;
        bit ft;
        model_reset();
        #1;
        reset = 1'b0;
        req_valid = '1;
        #2;
        check_reset_vals();
        req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        n_all = 0;
        for (int c = 0; c < 1030; c++) begin
            cyc(1'b0, '0);
            if (clr_en === 1'b1 && clr_all === 1'b1) n_all++;
        end
        chk("init_len", 32'(n_all), 32'(1024));
        chk("ready_clr_en", 32'(clr_en), 32'(0));

        for (int c = 0; c < 12; c++) cyc(1'b0, 4'b0101);

        // Grant and frame_tick together: the write lands in the SWAP cycle.
        cyc(1'b1, 4'b0101);
        for (int c = 0; c < 3000 && !(m_swaps == 2 && m_sweep == 300); c++) begin
            ft = (m_swaps == 1 && (m_sweep == 500 || m_sweep == 700)) ||
                 (m_swaps == 2 && m_sweep == 200);
            cyc(ft, N'($urandom));
        end
        chk("pre_reset_clr_addr", 32'(clr_addr), 32'(300));
        chk("pre_reset_overrun", 32'(overrun), 32'(1));
        chk("pre_reset_drop", 32'(drop_cnt), 32'(1));
        chk("pre_reset_bank", 32'(bank_sel), 32'(0));

        do_reset();
        for (int c = 0; c < 1020; c++) cyc(1'b1, N'($urandom));
        chk("drop_saturate", 32'(drop_cnt), 32'(255));
        chk("init_overrun", 32'(overrun), 32'(0));
        for (int c = 0; c < 300; c++) cyc(($urandom % 8) == 0, N'($urandom));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end
endmodule
